// File: rtl/ahb_interconnect.sv
// ahb_interconnect
// Single-master AHB-Lite interconnect for three slaves plus a default slave,
// with a data-phase watchdog that aborts a transfer stalled for too long.
//
// Parameters
//   TIMEOUT      consecutive data-phase wait cycles tolerated before the abort
//                (legal range 2..255)
// Ports
//   hclk         system clock, rising edge
//   hreset       asynchronous active-high reset
//   haddr        address-phase address (bits 31:28 decode the target)
//   htrans       transfer type; bit 1 marks NONSEQ/SEQ
//   hsel_s       one-hot select to slaves 0..2
//   hsel_d       select to the default slave
//   hrdata_s0..2, hrdata_d         slave read data
//   hreadyout_s, hreadyout_d       slave ready
//   hresp_s, hresp_d               slave response (1 = ERROR)
//   hrdata       muxed read data to the master
//   hready       muxed ready, broadcast to master and slaves
//   hresp        muxed response to the master
//   timeout_irq  one-cycle pulse in the second cycle of a watchdog abort
module ahb_interconnect #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  output logic [2:0]  hsel_s,
  output logic        hsel_d,
  input  logic [63:0] hrdata_s0,
  input  logic [63:0] hrdata_s1,
  input  logic [63:0] hrdata_s2,
  input  logic [63:0] hrdata_d,
  input  logic [2:0]  hreadyout_s,
  input  logic        hreadyout_d,
  input  logic [2:0]  hresp_s,
  input  logic        hresp_d,
  output logic [63:0] hrdata,
  output logic        hready,
  output logic        hresp,
  output logic        timeout_irq
);

  typedef enum logic [2:0] {
    DSEL_S0   = 3'd0,
    DSEL_S1   = 3'd1,
    DSEL_S2   = 3'd2,
    DSEL_D    = 3'd3,
    DSEL_NONE = 3'd4
  } dsel_t;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_ERR1   = 2'd1,
    ST_ERR2   = 2'd2
  } wd_state_t;

  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  dsel_t      dec_s;
  dsel_t      dsel_r;
  dsel_t      dsel_nxt_s;
  wd_state_t  state_r;
  wd_state_t  state_nxt_s;
  logic [7:0] wdcnt_r;
  logic [7:0] wdcnt_nxt_s;
  logic [63:0] slv_rdata_s;
  logic        slv_ready_s;
  logic        slv_resp_s;

  // Only the top address nibble and htrans[1] take part in routing.
  logic unused_inputs_s;
  assign unused_inputs_s = ^{haddr[27:0], htrans[0]};

  // Address decode and slave select, independent of htrans
  always_comb begin
    hsel_s = 3'b000;
    hsel_d = 1'b0;
    case (haddr[31:28])
      4'h0:    dec_s = DSEL_S0;
      4'h1:    dec_s = DSEL_S1;
      4'h2:    dec_s = DSEL_S2;
      default: dec_s = DSEL_D;
    endcase
    case (dec_s)
      DSEL_S0: hsel_s = 3'b001;
      DSEL_S1: hsel_s = 3'b010;
      DSEL_S2: hsel_s = 3'b100;
      default: hsel_d = 1'b1;
    endcase
  end

  // Data-phase slave mux; an idle data phase looks like a zero-wait OKAY
  always_comb begin
    case (dsel_r)
      DSEL_S0: begin
        slv_rdata_s = hrdata_s0;
        slv_ready_s = hreadyout_s[0];
        slv_resp_s  = hresp_s[0];
      end
      DSEL_S1: begin
        slv_rdata_s = hrdata_s1;
        slv_ready_s = hreadyout_s[1];
        slv_resp_s  = hresp_s[1];
      end
      DSEL_S2: begin
        slv_rdata_s = hrdata_s2;
        slv_ready_s = hreadyout_s[2];
        slv_resp_s  = hresp_s[2];
      end
      DSEL_D: begin
        slv_rdata_s = hrdata_d;
        slv_ready_s = hreadyout_d;
        slv_resp_s  = hresp_d;
      end
      default: begin
        slv_rdata_s = 64'd0;
        slv_ready_s = 1'b1;
        slv_resp_s  = 1'b0;
      end
    endcase
  end

  // Watchdog next state, counter and master-facing outputs
  always_comb begin
    state_nxt_s = state_r;
    wdcnt_nxt_s = wdcnt_r;
    hrdata      = slv_rdata_s;
    hready      = slv_ready_s;
    hresp       = slv_resp_s;
    timeout_irq = 1'b0;
    case (state_r)
      ST_NORMAL: begin
        // A ready in the last tolerated cycle takes the else branch and wins.
        if (!slv_ready_s) begin
          if (wdcnt_r == TIMEOUT_M1) begin
            state_nxt_s = ST_ERR1;
          end else begin
            wdcnt_nxt_s = wdcnt_r + 8'd1;
          end
        end else begin
          wdcnt_nxt_s = 8'd0;
        end
      end
      ST_ERR1: begin
        hrdata      = 64'd0;
        hready      = 1'b0;
        hresp       = 1'b1;
        wdcnt_nxt_s = 8'd0;
        state_nxt_s = ST_ERR2;
      end
      ST_ERR2: begin
        hrdata      = 64'd0;
        hready      = 1'b1;
        hresp       = 1'b1;
        timeout_irq = 1'b1;
        wdcnt_nxt_s = 8'd0;
        state_nxt_s = ST_NORMAL;
      end
      default: begin
        // Unreachable encoding: behave as an idle bus and recover.
        hrdata      = 64'd0;
        hready      = 1'b1;
        hresp       = 1'b0;
        wdcnt_nxt_s = 8'd0;
        state_nxt_s = ST_NORMAL;
      end
    endcase
  end

  // Data-phase select advances only when the bus is ready
  always_comb begin
    if (hready) begin
      if (htrans[1]) begin
        dsel_nxt_s = dec_s;
      end else begin
        dsel_nxt_s = DSEL_NONE;
      end
    end else begin
      dsel_nxt_s = dsel_r;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      dsel_r  <= DSEL_NONE;
      state_r <= ST_NORMAL;
      wdcnt_r <= 8'd0;
    end else begin
      dsel_r  <= dsel_nxt_s;
      state_r <= state_nxt_s;
      wdcnt_r <= wdcnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_ahb_interconnect.sv
module tb_ahb_interconnect;

  localparam int TO = 16;
  localparam logic [63:0] D_S0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D_S1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D_S2 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D_D  = 64'hDEAD_BEEF_0BAD_F00D;

  logic        hclk;
  logic        hreset;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsel_s;
  logic        hsel_d;
  logic [63:0] hrdata_s0, hrdata_s1, hrdata_s2, hrdata_d;
  logic [2:0]  hreadyout_s;
  logic        hreadyout_d;
  logic [2:0]  hresp_s;
  logic        hresp_d;
  logic [63:0] hrdata;
  logic        hready;
  logic        hresp;
  logic        timeout_irq;

  // bench-side slave models: index 3 is the default slave
  logic [63:0] rd [4];
  logic [3:0]  rdy;
  logic [3:0]  rsp;

  assign hrdata_s0   = rd[0];
  assign hrdata_s1   = rd[1];
  assign hrdata_s2   = rd[2];
  assign hrdata_d    = rd[3];
  assign hreadyout_s = rdy[2:0];
  assign hreadyout_d = rdy[3];
  assign hresp_s     = rsp[2:0];
  assign hresp_d     = rsp[3];

  ahb_interconnect #(.TIMEOUT(TO)) dut (
    .hclk(hclk), .hreset(hreset), .haddr(haddr), .htrans(htrans),
    .hsel_s(hsel_s), .hsel_d(hsel_d),
    .hrdata_s0(hrdata_s0), .hrdata_s1(hrdata_s1), .hrdata_s2(hrdata_s2), .hrdata_d(hrdata_d),
    .hreadyout_s(hreadyout_s), .hreadyout_d(hreadyout_d),
    .hresp_s(hresp_s), .hresp_d(hresp_d),
    .hrdata(hrdata), .hready(hready), .hresp(hresp), .timeout_irq(timeout_irq)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] sel, input logic r,
                            input logic e, input logic irq, input logic [63:0] d);
    chk({tag, " hsel"},  64'({hsel_d, hsel_s}), 64'(sel));
    chk({tag, " hready"}, 64'(hready), 64'(r));
    chk({tag, " hresp"},  64'(hresp), 64'(e));
    chk({tag, " irq"},    64'(timeout_irq), 64'(irq));
    chk({tag, " hrdata"}, hrdata, d);
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t,
                       input logic [3:0] r, input logic [3:0] e);
    haddr = a; htrans = t; rdy = r; rsp = e;
  endtask

  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // m_tgt: slave owning the current data phase (-1 = none)
  // m_waits: wait cycles seen so far in that data phase
  // m_abort: abort cycles still to run (2 = first, 1 = second)
  int m_tgt, m_waits, m_abort;

  function automatic int decode(input logic [31:0] a);
    if (a[31:28] <= 4'd2) return int'(a[31:28]);
    return 3;
  endfunction

  function automatic logic model_ready();
    if (m_abort == 2) return 1'b0;
    if (m_abort == 1) return 1'b1;
    if (m_tgt < 0) return 1'b1;
    return rdy[m_tgt];
  endfunction

  always @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      m_tgt   <= -1;
      m_waits <= 0;
      m_abort <= 0;
    end else if (m_abort == 2) begin
      m_abort <= 1;
    end else if (m_abort == 1) begin
      m_abort <= 0;
      m_waits <= 0;
      m_tgt   <= htrans[1] ? decode(haddr) : -1;
    end else if (model_ready()) begin
      m_waits <= 0;
      m_tgt   <= htrans[1] ? decode(haddr) : -1;
    end else if (m_waits + 1 == TO) begin
      m_abort <= 2;
      m_waits <= 0;
    end else begin
      m_waits <= m_waits + 1;
    end
  end

  task automatic model_check(input string tag);
    logic [3:0]  esel;
    logic        er, ee, ei;
    logic [63:0] ed;
    esel = 4'b0001 << decode(haddr);
    if (m_abort == 2) begin
      er = 1'b0; ee = 1'b1; ei = 1'b0; ed = 64'd0;
    end else if (m_abort == 1) begin
      er = 1'b1; ee = 1'b1; ei = 1'b1; ed = 64'd0;
    end else if (m_tgt < 0) begin
      er = 1'b1; ee = 1'b0; ei = 1'b0; ed = 64'd0;
    end else begin
      er = rdy[m_tgt]; ee = rsp[m_tgt]; ei = 1'b0; ed = rd[m_tgt];
    end
    expect_out(tag, esel, er, ee, ei, ed);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [3:0]  rdy;
    logic [3:0]  rsp;
    logic [3:0]  sel;
    logic        ordy;
    logic        orsp;
    logic [63:0] odata;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int stall_left;
    vecs[0]  = '{32'h1000_0000, 2'b10, 4'b1111, 4'b0000, 4'b0010, 1'b1, 1'b0, 64'd0};
    vecs[1]  = '{32'h0000_0000, 2'b00, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, D_S1};
    vecs[2]  = '{32'h7000_0000, 2'b10, 4'b1111, 4'b0000, 4'b1000, 1'b1, 1'b0, 64'd0};
    vecs[3]  = '{32'h7000_0000, 2'b00, 4'b0111, 4'b1000, 4'b1000, 1'b0, 1'b1, D_D};
    vecs[4]  = '{32'h7000_0000, 2'b00, 4'b1111, 4'b1000, 4'b1000, 1'b1, 1'b1, D_D};
    vecs[5]  = '{32'h2000_0000, 2'b10, 4'b1111, 4'b0000, 4'b0100, 1'b1, 1'b0, 64'd0};
    vecs[6]  = '{32'h3000_0000, 2'b11, 4'b1111, 4'b0000, 4'b1000, 1'b1, 1'b0, D_S2};
    vecs[7]  = '{32'hF000_0000, 2'b01, 4'b1111, 4'b0000, 4'b1000, 1'b1, 1'b0, D_D};
    vecs[8]  = '{32'h0000_0000, 2'b00, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, 64'd0};
    vecs[9]  = '{32'h0000_0000, 2'b10, 4'b1111, 4'b0001, 4'b0001, 1'b1, 1'b0, 64'd0};
    vecs[10] = '{32'h1000_0000, 2'b00, 4'b1110, 4'b0001, 4'b0010, 1'b0, 1'b1, D_S0};
    vecs[11] = '{32'h1000_0000, 2'b00, 4'b1111, 4'b0001, 4'b0010, 1'b1, 1'b1, D_S0};
    vecs[12] = '{32'h0000_0000, 2'b00, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, 64'd0};

    rd[0] = D_S0; rd[1] = D_S1; rd[2] = D_S2; rd[3] = D_D;

    // reset state, hsel still follows haddr, stalled slaves ignored
    hreset = 1'b1;
    drive(32'h2000_0000, 2'b10, 4'b0000, 4'b1111);
    #2;
    expect_out("reset", 4'b0100, 1'b1, 1'b0, 1'b0, 64'd0);
    next_cycle();
    hreset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].addr, vecs[i].trans, vecs[i].rdy, vecs[i].rsp);
      #2;
      expect_out($sformatf("vec%0d", i), vecs[i].sel, vecs[i].ordy, vecs[i].orsp, 1'b0, vecs[i].odata);
      next_cycle();
    end

    // five wait states on slave 0
    drive(32'h0000_0000, 2'b10, 4'b1111, 4'b0000); #2;
    expect_out("ws_addr", 4'b0001, 1'b1, 1'b0, 1'b0, 64'd0); next_cycle();
    for (int k = 0; k < 5; k++) begin
      drive(32'h0000_0000, 2'b00, 4'b1110, 4'b0000); #2;
      expect_out($sformatf("ws_wait%0d", k), 4'b0001, 1'b0, 1'b0, 1'b0, D_S0); next_cycle();
    end
    drive(32'h0000_0000, 2'b00, 4'b1111, 4'b0000); #2;
    expect_out("ws_done", 4'b0001, 1'b1, 1'b0, 1'b0, D_S0); next_cycle();

    // slave 2 stalls until the watchdog aborts
    drive(32'h2000_0000, 2'b10, 4'b1111, 4'b0000); #2;
    expect_out("to_addr", 4'b0100, 1'b1, 1'b0, 1'b0, 64'd0); next_cycle();
    for (int k = 0; k < TO; k++) begin
      drive(32'h0000_0000, 2'b00, 4'b1011, 4'b0000); #2;
      expect_out($sformatf("to_wait%0d", k), 4'b0001, 1'b0, 1'b0, 1'b0, D_S2); next_cycle();
    end
    drive(32'h0000_0000, 2'b00, 4'b1111, 4'b0000); #2;
    expect_out("to_err1", 4'b0001, 1'b0, 1'b1, 1'b0, 64'd0); next_cycle();
    drive(32'h0000_0000, 2'b00, 4'b1111, 4'b0000); #2;
    expect_out("to_err2", 4'b0001, 1'b1, 1'b1, 1'b1, 64'd0); next_cycle();
    drive(32'h0000_0000, 2'b00, 4'b1111, 4'b0000); #2;
    expect_out("to_after", 4'b0001, 1'b1, 1'b0, 1'b0, 64'd0); next_cycle();

    // ready arrives in the last tolerated cycle: normal completion
    drive(32'h0000_0000, 2'b10, 4'b1111, 4'b0000); #2;
    expect_out("bnd_addr", 4'b0001, 1'b1, 1'b0, 1'b0, 64'd0); next_cycle();
    for (int k = 0; k < TO - 1; k++) begin
      drive(32'h0000_0000, 2'b00, 4'b1110, 4'b0000); #2;
      expect_out($sformatf("bnd_wait%0d", k), 4'b0001, 1'b0, 1'b0, 1'b0, D_S0); next_cycle();
    end
    drive(32'h0000_0000, 2'b00, 4'b1111, 4'b0000); #2;
    expect_out("bnd_ready", 4'b0001, 1'b1, 1'b0, 1'b0, D_S0); next_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(32'h0000_0000, 2'b00, 4'b1111, 4'b0000); #2;
      expect_out("bnd_idle", 4'b0001, 1'b1, 1'b0, 1'b0, 64'd0); next_cycle();
    end

    // reset pulsed during the eighth wait cycle
    drive(32'h2000_0000, 2'b10, 4'b1111, 4'b0000); #2;
    expect_out("rst_addr", 4'b0100, 1'b1, 1'b0, 1'b0, 64'd0); next_cycle();
    for (int k = 0; k < 7; k++) begin
      drive(32'h0000_0000, 2'b00, 4'b1011, 4'b0000); #2;
      expect_out("rst_wait", 4'b0001, 1'b0, 1'b0, 1'b0, D_S2); next_cycle();
    end
    drive(32'h0000_0000, 2'b00, 4'b1011, 4'b0000); #2;
    expect_out("rst_wait8", 4'b0001, 1'b0, 1'b0, 1'b0, D_S2);
    haddr = 32'h1000_0000;
    hreset = 1'b1;
    #1;
    expect_out("rst_async", 4'b0010, 1'b1, 1'b0, 1'b0, 64'd0);
    next_cycle();
    hreset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(32'h0000_0000, 2'b00, 4'b1011, 4'b0000); #2;
      expect_out("rst_release", 4'b0001, 1'b1, 1'b0, 1'b0, 64'd0); next_cycle();
    end
    drive(32'h2000_0000, 2'b10, 4'b1111, 4'b0000); next_cycle();
    for (int k = 0; k < TO - 1; k++) begin
      drive(32'h0000_0000, 2'b00, 4'b1011, 4'b0000); #2;
      expect_out("rst_restall", 4'b0001, 1'b0, 1'b0, 1'b0, D_S2); next_cycle();
    end
    drive(32'h0000_0000, 2'b00, 4'b1111, 4'b0000); #2;
    expect_out("rst_redone", 4'b0001, 1'b1, 1'b0, 1'b0, D_S2); next_cycle();

    // randomized traffic against the reference model
    stall_left = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] nib;
      nib = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) nib = 4'($urandom_range(0, 2));
      haddr  = {nib, 28'($urandom)};
      htrans = 2'($urandom);
      if (stall_left == 0 && $urandom_range(0, 59) == 0) stall_left = $urandom_range(10, 25);
      if (stall_left > 0) begin
        rdy = 4'b0000;
        stall_left--;
      end else begin
        rdy = 4'($urandom) | 4'($urandom);
      end
      rsp = 4'($urandom) & 4'($urandom) & 4'($urandom);
      for (int s = 0; s < 4; s++) rd[s] = {$urandom, $urandom};
      hreset = ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0;
      #2;
      model_check($sformatf("rand%0d", n));
      next_cycle();
    end
    hreset = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ahb_interconnect.md
AHB_INTERCONNECT -- requirements
Module: ahb_interconnect

Interface
REQ-001 Parameter: TIMEOUT, default 16, number of consecutive data-phase wait cycles tolerated before the block aborts the transfer (legal range 2..255).
REQ-002 HCLK  in  1  system clock; all state updates on the rising edge.
REQ-003 HRESET  in  1  asynchronous, active-high reset.
REQ-004 HADDR  in  32  master address-phase address.
REQ-005 HTRANS  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-006 HSEL_S  out  3  one-hot select to slaves 0..2.
REQ-007 HSEL_D  out  1  select to the default slave.
REQ-008 HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_D  in  64 each  slave read data.
REQ-009 HREADYOUT_S  in  3  slave 0..2 ready; HREADYOUT_D  in  1  default slave ready.
REQ-010 HRESP_S  in  3  slave 0..2 response; HRESP_D  in  1  default slave response.
REQ-011 HRDATA  out  64  muxed read data to the master.
REQ-012 HREADY  out  1  muxed ready, broadcast to the master and all slaves.
REQ-013 HRESP  out  1  muxed response to the master (1 = ERROR).
REQ-014 TIMEOUT_IRQ  out  1  one-cycle pulse when the watchdog aborts a transfer.

Function
REQ-015 Decode shall be combinational from HADDR[31:28]: 0x0 selects slave 0, 0x1 selects slave 1, 0x2 selects slave 2, and all other values select the default slave.
REQ-016 Exactly one of HSEL_S[2:0] and HSEL_D shall be high at all times, independent of HTRANS.
REQ-017 A data-phase select register DSEL (values S0, S1, S2, D, NONE) shall load on each HCLK edge with HREADY=1: the decoded target if HTRANS[1]=1, otherwise NONE.
REQ-018 DSEL shall hold its value while HREADY=0.
REQ-019 With DSEL=NONE: HRDATA=0, HREADY=1, HRESP=0.
REQ-020 Otherwise, in state NORMAL: HRDATA, HREADY and HRESP shall equal the HRDATA, HREADYOUT and HRESP of the slave named by DSEL, with zero added latency.
REQ-021 Watchdog FSM states: NORMAL, ERR1, ERR2.
REQ-022 8-bit counter WDCNT, in NORMAL only: cleared when HREADY=1, incremented when DSEL!=NONE and the selected slave's HREADYOUT=0.
REQ-023 In NORMAL, if the selected HREADYOUT=0 and WDCNT=TIMEOUT-1, the next state shall be ERR1; WDCNT shall not wrap.
REQ-024 ERR1 shall drive HREADY=0, HRESP=1, HRDATA=0, and unconditionally go to ERR2 next cycle.
REQ-025 ERR2 shall drive HREADY=1, HRESP=1, HRDATA=0, TIMEOUT_IRQ=1, and go to NORMAL with WDCNT=0.
REQ-026 In ERR2, DSEL shall update per REQ-017.
REQ-027 In ERR1 and ERR2, the slave outputs shall be ignored.
REQ-028 If the selected slave raises HREADYOUT=1 in the same cycle WDCNT=TIMEOUT-1, the ready shall win: no abort, and WDCNT shall be cleared.
REQ-029 Slave-originated ERROR responses, including the default slave's two-cycle ERROR, shall pass through unchanged and shall not affect WDCNT beyond REQ-022.
REQ-030 TIMEOUT_IRQ shall be 0 in all states except ERR2.

Reset
REQ-031 While HRESET=1: DSEL=NONE, state NORMAL, WDCNT=0.
REQ-032 While HRESET=1, the outputs shall be HRDATA=0, HREADY=1, HRESP=0, TIMEOUT_IRQ=0.
REQ-033 HSEL outputs shall continue to follow HADDR during reset.
REQ-034 Reset asserted mid-transfer or in ERR1/ERR2 shall abandon the transfer immediately, with no IRQ pulse.

Verification
REQ-035 Basic read: HADDR=0x1000_0000 NONSEQ, then S1 returns HRDATA_S1=0x0123_4567_89AB_CDEF with ready -> HSEL_S=010 in the address phase; HRDATA=0x0123456789ABCDEF and HREADY=1 in the next cycle.
REQ-036 Default route: HADDR=0x7000_0000 NONSEQ; default slave drives HRESP_D=1 with HREADYOUT_D=0, then 1 -> HSEL_D=1; HRESP=1 for two cycles; HREADY=0 then 1; TIMEOUT_IRQ=0.
REQ-037 Wait states: S0 holds HREADYOUT_S[0]=0 for 5 cycles (TIMEOUT=16) -> HREADY=0 for 5 cycles, then 1; HRESP=0; no IRQ.
REQ-038 Timeout: S2 stalls indefinitely (TIMEOUT=16) -> HREADY=0 for 16 cycles; ERR1 (HREADY=0, HRESP=1); ERR2 (HREADY=1, HRESP=1, TIMEOUT_IRQ=1); next IDLE -> DSEL=NONE, HREADY=1.
REQ-039 Boundary: S0 asserts ready exactly on wait cycle 16 -> normal completion with HRESP=0; IRQ stays 0.
REQ-040 Reset mid-stall: HRESET pulsed during wait cycle 8 -> HREADY=1, HRESP=0 asynchronously; WDCNT=0; no IRQ after release.
